// File: rtl/step_sequencer_mixer.sv
`default_nettype none
// ============================================================================
// Module   : step_sequencer_mixer
// Brief    : Multi-track step sequencer with per-track sample voices and a
//            saturating mixer producing one signed PCM word per audio strobe.
// Revision : 1.0 - initial release
// ============================================================================
module step_sequencer_mixer #(
    parameter int STEPS      = 16,
    parameter int TRACKS     = 4,
    parameter int PCM_W      = 24,
    parameter int ADDR_W     = 14,
    parameter int SAMPLE_LEN = 12000
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         beat,
    input  logic                         advance,
    input  logic                         mode,
    input  logic [$clog2(TRACKS)-1:0]    edit_track,
    input  logic [$clog2(STEPS)-1:0]     edit_step,
    input  logic                         edit_toggle,
    input  logic                         clear_track,
    input  logic [TRACKS*PCM_W-1:0]      sample_in,
    output logic [TRACKS*ADDR_W-1:0]     sample_addr,
    output logic [$clog2(STEPS)-1:0]     step_idx,
    output logic [STEPS-1:0]             step_onehot,
    output logic [STEPS-1:0]             step_leds,
    output logic [TRACKS-1:0]            trigger,
    output logic [TRACKS-1:0]            voice_active,
    output logic [PCM_W-1:0]             pcm_out
);

    localparam int SB    = $clog2(STEPS);
    localparam int TB    = $clog2(TRACKS);
    localparam int SUM_W = PCM_W + TB;

    typedef enum logic [0:0] {
        V_IDLE = 1'b0,
        V_PLAY = 1'b1
    } voice_state_t;

    logic [STEPS-1:0]  r_pattern [TRACKS];
    logic [SB-1:0]     r_step_idx;
    logic [TRACKS-1:0] r_trigger;
    logic [PCM_W-1:0]  r_pcm;

    logic [SB-1:0]     w_step_next;
    logic              w_trk_ok;
    logic              w_stp_ok;
    logic              w_edit_ok;
    logic [TRACKS-1:0] w_active;
    logic [SUM_W-1:0]  w_ext [TRACKS];
    logic [SUM_W-1:0]  w_sum;
    logic [TB:0]       w_sum_top;
    logic [PCM_W-1:0]  w_mix;

    assign w_step_next = (r_step_idx == SB'(STEPS - 1)) ? '0 : r_step_idx + SB'(1);
    assign w_trk_ok    = (32'(edit_track) < TRACKS);
    assign w_stp_ok    = (32'(edit_step) < STEPS);
    assign w_edit_ok   = ~mode & w_trk_ok & w_stp_ok;

    // Trigger samples the grid as it stood before any same-cycle edit lands.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_step_idx <= SB'(STEPS - 1);
            r_trigger  <= '0;
            for (int t = 0; t < TRACKS; t++) begin
                r_pattern[t] <= '0;
            end
        end else begin
            r_trigger <= '0;
            if (beat) begin
                r_step_idx <= w_step_next;
                for (int t = 0; t < TRACKS; t++) begin
                    r_trigger[t] <= r_pattern[t][w_step_next];
                end
            end
            if (w_edit_ok) begin
                if (clear_track) begin
                    r_pattern[edit_track] <= '0;
                end else if (edit_toggle) begin
                    r_pattern[edit_track][edit_step] <= ~r_pattern[edit_track][edit_step];
                end
            end
        end
    end

    for (genvar t = 0; t < TRACKS; t++) begin : g_voice
        voice_state_t      r_state;
        voice_state_t      w_state_nxt;
        logic [ADDR_W-1:0] r_addr;
        logic [ADDR_W-1:0] w_addr_nxt;

        always_ff @(posedge clock) begin
            if (reset) begin
                r_state <= V_IDLE;
                r_addr  <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_addr  <= w_addr_nxt;
            end
        end

        // A retrigger restarts the sample and overrides a coincident advance.
        always_comb begin
            w_state_nxt = r_state;
            w_addr_nxt  = r_addr;
            case (r_state)
                V_IDLE: begin
                    w_addr_nxt = '0;
                    if (r_trigger[t]) begin
                        w_state_nxt = V_PLAY;
                    end
                end
                V_PLAY: begin
                    if (r_trigger[t]) begin
                        w_addr_nxt = '0;
                    end else if (advance) begin
                        if (r_addr == ADDR_W'(SAMPLE_LEN - 1)) begin
                            w_state_nxt = V_IDLE;
                            w_addr_nxt  = '0;
                        end else begin
                            w_addr_nxt = r_addr + ADDR_W'(1);
                        end
                    end
                end
                default: begin
                    w_state_nxt = V_IDLE;
                    w_addr_nxt  = '0;
                end
            endcase
        end

        assign w_active[t]                       = (r_state == V_PLAY);
        assign sample_addr[t*ADDR_W +: ADDR_W]   = r_addr;
        assign w_ext[t] = {{TB{sample_in[(t+1)*PCM_W-1]}}, sample_in[t*PCM_W +: PCM_W]};
    end

    always_comb begin
        w_sum = '0;
        for (int t = 0; t < TRACKS; t++) begin
            if (w_active[t]) begin
                w_sum = w_sum + w_ext[t];
            end
        end
    end

    // The sum cannot wrap in SUM_W bits, so overflow shows as disagreeing top bits.
    assign w_sum_top = w_sum[SUM_W-1:PCM_W-1];

    always_comb begin
        w_mix = w_sum[PCM_W-1:0];
        if (!((&w_sum_top) || (~|w_sum_top))) begin
            w_mix = w_sum[SUM_W-1] ? {1'b1, {(PCM_W-1){1'b0}}}
                                   : {1'b0, {(PCM_W-1){1'b1}}};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pcm <= '0;
        end else if (advance) begin
            r_pcm <= w_mix;
        end
    end

    assign step_idx     = r_step_idx;
    assign step_onehot  = STEPS'(1) << r_step_idx;
    assign step_leds    = w_trk_ok ? r_pattern[edit_track] : '0;
    assign trigger      = r_trigger;
    assign voice_active = w_active;
    assign pcm_out      = r_pcm;

endmodule
`default_nettype wire

// File: tb/tb_step_sequencer_mixer.sv
`default_nettype none
// ============================================================================
// Module   : tb_step_sequencer_mixer
// Brief    : Directed scoreboard bench for step_sequencer_mixer (4 tracks,
//            16 steps, 4-sample voices).
// Revision : 1.0 - initial release
// ============================================================================
module tb_step_sequencer_mixer;

    logic        clock;
    logic        reset;
    logic        beat;
    logic        advance;
    logic        mode;
    logic [1:0]  edit_track;
    logic [3:0]  edit_step;
    logic        edit_toggle;
    logic        clear_track;
    logic [95:0] sample_in;
    logic [55:0] sample_addr;
    logic [3:0]  step_idx;
    logic [15:0] step_onehot;
    logic [15:0] step_leds;
    logic [3:0]  trigger;
    logic [3:0]  voice_active;
    logic [23:0] pcm_out;

    int total = 0;
    int bad   = 0;
    int rom_mode = 0;

    logic [23:0] pcm_q  [$];
    logic [3:0]  trig_q [$];
    logic        adv_d;
    logic        beat_d;

    step_sequencer_mixer #(
        .STEPS(16), .TRACKS(4), .PCM_W(24), .ADDR_W(14), .SAMPLE_LEN(4)
    ) dut (
        .clock(clock), .reset(reset), .beat(beat), .advance(advance), .mode(mode),
        .edit_track(edit_track), .edit_step(edit_step), .edit_toggle(edit_toggle),
        .clear_track(clear_track), .sample_in(sample_in), .sample_addr(sample_addr),
        .step_idx(step_idx), .step_onehot(step_onehot), .step_leds(step_leds),
        .trigger(trigger), .voice_active(voice_active), .pcm_out(pcm_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Sample ROMs: track 0 holds 10,20,30,40; other modes give fixed per-track words.
    always_comb begin
        sample_in = '0;
        for (int t = 0; t < 4; t++) begin
            case (rom_mode)
                0: if (t == 0) begin
                    case (sample_addr[13:0])
                        14'd0:   sample_in[23:0] = 24'd10;
                        14'd1:   sample_in[23:0] = 24'd20;
                        14'd2:   sample_in[23:0] = 24'd30;
                        14'd3:   sample_in[23:0] = 24'd40;
                        default: sample_in[23:0] = 24'd0;
                    endcase
                end
                1: sample_in[t*24 +: 24] = 24'h600000;
                2: sample_in[t*24 +: 24] = 24'h900000;
                default: case (t)
                    0:       sample_in[t*24 +: 24] = 24'd100;
                    1:       sample_in[t*24 +: 24] = 24'hFFFFE2;
                    2:       sample_in[t*24 +: 24] = 24'd5;
                    default: sample_in[t*24 +: 24] = 24'hFFFFFF;
                endcase
            endcase
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(posedge clock) begin
        adv_d  <= advance & ~reset;
        beat_d <= beat & ~reset;
    end

    always @(negedge clock) begin
        if (adv_d) begin
            if (pcm_q.size() == 0) begin
                total++; bad++;
                $display("FAIL pcm_unexpected: got %0h expected none", pcm_out);
            end else begin
                chk("pcm_out", 64'(pcm_out), 64'(pcm_q.pop_front()));
            end
        end
        if (beat_d) begin
            if (trig_q.size() == 0) begin
                total++; bad++;
                $display("FAIL trig_unexpected: got %0h expected none", trigger);
            end else begin
                chk("trigger", 64'(trigger), 64'(trig_q.pop_front()));
            end
        end
    end

    task automatic cyc();
        @(posedge clock); #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic do_beat(input logic [3:0] exp_trig);
        trig_q.push_back(exp_trig);
        beat = 1'b1;
        cyc();
        beat = 1'b0;
    endtask

    task automatic do_adv(input logic [23:0] exp_pcm);
        pcm_q.push_back(exp_pcm);
        advance = 1'b1;
        cyc();
        advance = 1'b0;
    endtask

    task automatic do_toggle(input logic [1:0] t, input logic [3:0] s);
        edit_track  = t;
        edit_step   = s;
        edit_toggle = 1'b1;
        cyc();
        edit_toggle = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; beat = 1'b0; advance = 1'b0; mode = 1'b0;
        edit_track = '0; edit_step = '0; edit_toggle = 1'b0; clear_track = 1'b0;
        do_reset();

        chk("rst_step_idx", 64'(step_idx), 64'd15);
        chk("rst_onehot", 64'(step_onehot), 64'h8000);
        chk("rst_trigger", 64'(trigger), 64'd0);
        chk("rst_active", 64'(voice_active), 64'd0);
        chk("rst_addr", 64'(sample_addr), 64'd0);
        chk("rst_pcm", 64'(pcm_out), 64'd0);
        chk("rst_leds", 64'(step_leds), 64'd0);

        // Empty pattern: step counter walks and wraps, nothing triggers.
        for (int i = 0; i < 16; i++) begin
            do_beat(4'b0000);
            chk("step_walk", 64'(step_idx), 64'(i));
        end
        do_beat(4'b0000);
        chk("step_wrap", 64'(step_idx), 64'd0);
        chk("onehot_wrap", 64'(step_onehot), 64'h0001);
        cyc();
        do_adv(24'd0);

        // Voice lifecycle on track 0.
        do_reset();
        do_toggle(2'd0, 4'd0);
        do_toggle(2'd0, 4'd4);
        chk("leds_t0", 64'(step_leds), 64'h0011);
        do_beat(4'b0001);
        cyc();
        chk("active_start", 64'(voice_active), 64'b0001);
        do_adv(24'd10);
        do_adv(24'd20);
        do_adv(24'd30);
        chk("active_mid", 64'(voice_active), 64'b0001);
        do_adv(24'd40);
        chk("active_end", 64'(voice_active), 64'b0000);
        do_adv(24'd0);

        // Retrigger coinciding with an advance at addr 2.
        do_toggle(2'd0, 4'd1);
        do_toggle(2'd0, 4'd2);
        do_beat(4'b0001);
        cyc();
        do_adv(24'd10);
        do_adv(24'd20);
        chk("addr_before_retrig", 64'(sample_addr[13:0]), 64'd2);
        do_beat(4'b0001);
        do_adv(24'd30);
        chk("addr_retrig", 64'(sample_addr[13:0]), 64'd0);
        chk("active_retrig", 64'(voice_active), 64'b0001);
        do_adv(24'd10);
        do_adv(24'd20);
        do_adv(24'd30);
        do_adv(24'd40);
        chk("active_after_retrig", 64'(voice_active), 64'b0000);

        // Edit rules.
        edit_track = 2'd0;
        cyc();
        chk("leds_t0_full", 64'(step_leds), 64'h0017);
        mode = 1'b1;
        do_toggle(2'd1, 4'd5);
        chk("play_mode_toggle", 64'(step_leds), 64'h0000);
        mode = 1'b0;
        do_toggle(2'd1, 4'd5);
        chk("write_mode_toggle", 64'(step_leds), 64'h0020);
        edit_track  = 2'd1;
        edit_step   = 4'd6;
        clear_track = 1'b1;
        edit_toggle = 1'b1;
        cyc();
        clear_track = 1'b0;
        edit_toggle = 1'b0;
        chk("clear_wins", 64'(step_leds), 64'h0000);

        // Toggle landing on the beat for the new step: trigger sees old grid.
        edit_track  = 2'd2;
        edit_step   = 4'd3;
        edit_toggle = 1'b1;
        do_beat(4'b0000);
        edit_toggle = 1'b0;
        chk("beat_step3", 64'(step_idx), 64'd3);
        chk("edit_on_beat_leds", 64'(step_leds), 64'h0008);

        // Saturation and signed mixing with all four voices.
        do_reset();
        for (int t = 0; t < 4; t++) do_toggle(2'(t), 4'd0);
        rom_mode = 1;
        do_beat(4'b1111);
        cyc();
        chk("active_all", 64'(voice_active), 64'b1111);
        do_adv(24'h7FFFFF);
        rom_mode = 2;
        do_adv(24'h800000);
        rom_mode = 3;
        do_adv(24'd74);

        // Mid-playback reset, with a concurrent advance that must not mix.
        reset   = 1'b1;
        advance = 1'b1;
        cyc();
        reset   = 1'b0;
        advance = 1'b0;
        chk("midrst_pcm", 64'(pcm_out), 64'd0);
        chk("midrst_active", 64'(voice_active), 64'd0);
        chk("midrst_step", 64'(step_idx), 64'd15);
        chk("midrst_addr", 64'(sample_addr), 64'd0);
        edit_track = 2'd0;
        cyc();
        chk("midrst_leds", 64'(step_leds), 64'd0);
        do_adv(24'd0);

        repeat (3) cyc();
        chk("pcm_q_drained", 64'(pcm_q.size()), 64'd0);
        chk("trig_q_drained", 64'(trig_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
